mem_exe_unit: RTL and testbench

- Execute stage for load/store ops, directly downstream of the select/wakeup stage's in-order memory reservation station.
- Latches one issued memory op, computes the effective address, and runs a req/gnt/rvalid transaction on the data-memory port.
- Produces a tagged writeback result that feeds one of the five execute forwarding buses (exe_result_N / exe_result_N_dst).
- Single-op occupancy; back-pressures issue via busy_o.

---
 rtl/mem_exe_unit_pkg.sv | 38 +++
 rtl/mem_exe_unit_if.sv | 25 ++
 rtl/mem_exe_unit_load_aligner.sv | 28 ++
 rtl/mem_exe_unit.sv | 177 +++++++++++++++++
 tb/tb_mem_exe_unit.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_exe_unit_pkg.sv
// Shared types for the load/store execute unit: ldst_type field layout,
// access-size encodings, FSM states and small address helpers.
package mem_exe_unit_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;
    localparam int TAG_W_DEF  = 6;

    // ldst_type = {is_store, unsigned, size[1:0]}
    localparam int LDST_STORE    = 3;
    localparam int LDST_UNSIGNED = 2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] ea_lo);
        return ((size == SZ_H) && ea_lo[0]) || ((size == SZ_W) && (ea_lo != 2'b00));
    endfunction

    function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] ea_lo);
        logic [3:0] strb;
        case (size)
            SZ_B:    strb = 4'b0001 << ea_lo;
            SZ_H:    strb = 4'b0011 << ea_lo;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/mem_exe_unit_if.sv
// Data-memory port of the load/store unit: req/gnt request phase plus
// rvalid response phase.
interface mem_exe_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              dmem_req_o;
    logic              dmem_we_o;
    logic [ADDR_W-1:0] dmem_addr_o;
    logic [DATA_W-1:0] dmem_wdata_o;
    logic [3:0]        dmem_wstrb_o;
    logic              dmem_gnt_i;
    logic              dmem_rvalid_i;
    logic [DATA_W-1:0] dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );
endinterface

// File: rtl/mem_exe_unit_load_aligner.sv
// Picks the addressed byte/half out of a loaded word and sign- or
// zero-extends it to the full data width.
module mem_exe_unit_load_aligner
    import mem_exe_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        ea_lo_i,
    input  logic [1:0]        size_i,
    input  logic              uns_i,
    output logic [DATA_W-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{ea_lo_i, 3'b000} +: 8];
        half_sel = ea_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            SZ_B:    data_o = {{(DATA_W-8){~uns_i & byte_sel[7]}}, byte_sel};
            SZ_H:    data_o = {{(DATA_W-16){~uns_i & half_sel[15]}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_exe_unit.sv
// Load/store execute stage: holds one memory op, runs it on the dmem port
// and returns a tagged writeback result or a misalignment fault.
//
// state | meaning
// IDLE  | empty, accepting issue_i
// REQ   | dmem_req_o held until granted
// WAIT  | granted, waiting for rvalid (drop_q set => discard on arrival)
// DONE  | one-cycle completion / fault report
module mem_exe_unit
    import mem_exe_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              issue_i,
    input  logic [DATA_W-1:0] op_1_i,
    input  logic [DATA_W-1:0] op_2_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [TAG_W-1:0]  rrf_tag_i,
    input  logic              dst_val_i,
    input  logic [3:0]        ldst_type_i,
    input  logic              kill_i,
    output logic              busy_o,
    mem_exe_unit_if.master    dmem,
    output logic [DATA_W-1:0] result_o,
    output logic [TAG_W-1:0]  result_dst_o,
    output logic              result_valid_o,
    output logic              done_o,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] fault_pc_o
);

    state_e            state_q;
    logic [1:0]        ea_lo_q;
    logic [3:0]        type_q;
    logic [TAG_W-1:0]  tag_q;
    logic              dst_val_q;
    logic              drop_q;
    logic              req_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic              done_q, result_valid_q, misalign_q;
    logic [DATA_W-1:0] result_q;
    logic [TAG_W-1:0]  result_dst_q;
    logic [ADDR_W-1:0] fault_pc_q;

    logic [ADDR_W-1:0] ea_d;
    logic [DATA_W-1:0] wdata_d;
    logic [DATA_W-1:0] load_ext;
    logic              finish_now;

    assign ea_d = ADDR_W'(op_1_i + imm_i);

    always_comb begin
        case (ldst_type_i[1:0])
            SZ_B:    wdata_d = {4{op_2_i[7:0]}};
            SZ_H:    wdata_d = {2{op_2_i[15:0]}};
            default: wdata_d = op_2_i;
        endcase
    end

    mem_exe_unit_load_aligner #(.DATA_W(DATA_W)) u_load_aligner (
        .rdata_i (dmem.dmem_rdata_i),
        .ea_lo_i (ea_lo_q),
        .size_i  (type_q[1:0]),
        .uns_i   (type_q[LDST_UNSIGNED]),
        .data_o  (load_ext)
    );

    // Completion only from a live (not killed, not draining) response.
    assign finish_now = !kill_i && dmem.dmem_rvalid_i &&
                        (((state_q == ST_REQ) && dmem.dmem_gnt_i) ||
                         ((state_q == ST_WAIT) && !drop_q));

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q        <= ST_IDLE;
            ea_lo_q        <= '0;
            type_q         <= '0;
            tag_q          <= '0;
            dst_val_q      <= 1'b0;
            drop_q         <= 1'b0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            misalign_q     <= 1'b0;
            result_q       <= '0;
            result_dst_q   <= '0;
            fault_pc_q     <= '0;
        end else begin
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            misalign_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    result_q     <= '0;
                    result_dst_q <= '0;
                    fault_pc_q   <= '0;
                    if (issue_i && !kill_i) begin
                        ea_lo_q   <= ea_d[1:0];
                        type_q    <= ldst_type_i;
                        tag_q     <= rrf_tag_i;
                        dst_val_q <= dst_val_i;
                        if (is_misaligned(ldst_type_i[1:0], ea_d[1:0])) begin
                            state_q      <= ST_DONE;
                            done_q       <= 1'b1;
                            misalign_q   <= 1'b1;
                            fault_pc_q   <= pc_i;
                            result_dst_q <= rrf_tag_i;
                        end else begin
                            state_q <= ST_REQ;
                            req_q   <= 1'b1;
                            we_q    <= ldst_type_i[LDST_STORE];
                            addr_q  <= {ea_d[ADDR_W-1:2], 2'b00};
                            wdata_q <= wdata_d;
                            wstrb_q <= lane_strobe(ldst_type_i[1:0], ea_d[1:0]);
                        end
                    end
                end
                ST_REQ: begin
                    if (kill_i) begin
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                    end else if (dmem.dmem_gnt_i) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (kill_i) drop_q <= 1'b1;
                    if (dmem.dmem_rvalid_i && (drop_q || kill_i)) begin
                        state_q <= ST_IDLE;
                        drop_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (finish_now) begin
                state_q        <= ST_DONE;
                done_q         <= 1'b1;
                result_dst_q   <= tag_q;
                result_q       <= type_q[LDST_STORE] ? '0 : load_ext;
                result_valid_q <= dst_val_q & ~type_q[LDST_STORE];
            end
        end
    end

    assign busy_o            = (state_q != ST_IDLE);
    assign dmem.dmem_req_o   = req_q;
    assign dmem.dmem_we_o    = we_q;
    assign dmem.dmem_addr_o  = addr_q;
    assign dmem.dmem_wdata_o = wdata_q;
    assign dmem.dmem_wstrb_o = wstrb_q;
    // A flush landing on the DONE cycle swallows the completion strobes.
    assign done_o            = done_q & ~kill_i;
    assign result_valid_o    = result_valid_q & ~kill_i;
    assign misalign_o        = misalign_q & ~kill_i;
    assign result_o          = result_q;
    assign result_dst_o      = result_dst_q;
    assign fault_pc_o        = fault_pc_q;

    a_no_issue_when_busy: assert property (
        @(posedge clk_i) disable iff (!reset_i) !(busy_o && issue_i)
    );

endmodule

// File: tb/tb_mem_exe_unit.sv
// Directed bench for mem_exe_unit with hand-computed expectations and a
// scripted data-memory responder.
module tb_mem_exe_unit;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        issue_i, dst_val_i, kill_i;
    logic [31:0] op_1_i, op_2_i, imm_i, pc_i;
    logic [5:0]  rrf_tag_i;
    logic [3:0]  ldst_type_i;
    logic        busy_o, result_valid_o, done_o, misalign_o;
    logic [31:0] result_o, fault_pc_o;
    logic [5:0]  result_dst_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        exp_we;

    mem_exe_unit_if #(.ADDR_W(32), .DATA_W(32)) dmem ();

    mem_exe_unit dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .issue_i        (issue_i),
        .op_1_i         (op_1_i),
        .op_2_i         (op_2_i),
        .imm_i          (imm_i),
        .pc_i           (pc_i),
        .rrf_tag_i      (rrf_tag_i),
        .dst_val_i      (dst_val_i),
        .ldst_type_i    (ldst_type_i),
        .kill_i         (kill_i),
        .busy_o         (busy_o),
        .dmem           (dmem),
        .result_o       (result_o),
        .result_dst_o   (result_dst_o),
        .result_valid_o (result_valid_o),
        .done_o         (done_o),
        .misalign_o     (misalign_o),
        .fault_pc_o     (fault_pc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one issue cycle, starting in an IDLE cycle; returns #1 after the capturing edge.
    task automatic issue_op(input logic [31:0] op1, input logic [31:0] op2, input logic [31:0] imm,
                            input logic [31:0] pc, input logic [5:0] tag, input logic dv,
                            input logic [3:0] ty);
        @(posedge clk_i); #1;
        op_1_i = op1; op_2_i = op2; imm_i = imm; pc_i = pc;
        rrf_tag_i = tag; dst_val_i = dv; ldst_type_i = ty; issue_i = 1'b1;
        @(negedge clk_i);
        chk("idle_busy", busy_o, 0);
        @(posedge clk_i); #1;
        issue_i = 1'b0;
    endtask

    // Holds gnt off for gnt_wait cycles, checking the request stays put, then answers.
    task automatic mem_serve(input int gnt_wait, input logic same, input logic [31:0] rd);
        for (int i = 0; i <= gnt_wait; i++) begin
            @(negedge clk_i);
            chk("req", dmem.dmem_req_o, 1);
            chk("addr", dmem.dmem_addr_o, exp_addr);
            chk("wstrb", dmem.dmem_wstrb_o, exp_wstrb);
            chk("we", dmem.dmem_we_o, exp_we);
            chk("busy", busy_o, 1);
            if (exp_we) chk("wdata", dmem.dmem_wdata_o, exp_wdata);
            if (i == gnt_wait) begin
                dmem.dmem_gnt_i = 1'b1;
                if (same) begin
                    dmem.dmem_rvalid_i = 1'b1;
                    dmem.dmem_rdata_i  = rd;
                end
            end
            @(posedge clk_i); #1;
            dmem.dmem_gnt_i    = 1'b0;
            dmem.dmem_rvalid_i = 1'b0;
        end
        if (!same) begin
            chk("wait_req_low", dmem.dmem_req_o, 0);
            chk("wait_no_done", done_o, 0);
            dmem.dmem_rvalid_i = 1'b1;
            dmem.dmem_rdata_i  = rd;
            @(posedge clk_i); #1;
            dmem.dmem_rvalid_i = 1'b0;
        end
    endtask

    task automatic done_chk(input string tag, input logic [31:0] res, input logic rv,
                            input logic [5:0] dst);
        @(negedge clk_i);
        chk({tag, "_done"}, done_o, 1);
        chk({tag, "_res"}, result_o, res);
        chk({tag, "_rv"}, result_valid_o, rv);
        if (rv) chk({tag, "_dst"}, result_dst_o, dst);
        chk({tag, "_mis"}, misalign_o, 0);
    endtask

    initial begin
        reset_i = 1'b0;
        issue_i = 0; kill_i = 0; dst_val_i = 0;
        op_1_i = 0; op_2_i = 0; imm_i = 0; pc_i = 0; rrf_tag_i = 0; ldst_type_i = 0;
        dmem.dmem_gnt_i = 0; dmem.dmem_rvalid_i = 0; dmem.dmem_rdata_i = 0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_busy", busy_o, 0);
        chk("rst_req", dmem.dmem_req_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_rv", result_valid_o, 0);
        chk("rst_addr", dmem.dmem_addr_o, 0);
        chk("rst_res", result_o, 0);
        reset_i = 1'b1;

        // LW 0x1000+4, gnt first REQ cycle, rvalid next -> result at N+3
        exp_addr = 32'h1004; exp_wstrb = 4'b1111; exp_we = 0; exp_wdata = 0;
        issue_op(32'h1000, 32'h0, 32'd4, 32'h10, 6'd5, 1'b1, 4'b0010);
        mem_serve(0, 1'b0, 32'hDEADBEEF);
        done_chk("lw", 32'hDEADBEEF, 1'b1, 6'd5);

        // LB signed ea=0x2003, gnt and rvalid together
        exp_addr = 32'h2000; exp_wstrb = 4'b1000;
        issue_op(32'h2000, 32'h0, 32'd3, 32'h14, 6'd7, 1'b1, 4'b0000);
        mem_serve(0, 1'b1, 32'h80AA5511);
        done_chk("lb", 32'hFFFFFF80, 1'b1, 6'd7);

        // LBU same address
        issue_op(32'h2000, 32'h0, 32'd3, 32'h18, 6'd8, 1'b1, 4'b0100);
        mem_serve(0, 1'b0, 32'h80AA5511);
        done_chk("lbu", 32'h00000080, 1'b1, 6'd8);

        // SH ea=0x3002
        exp_addr = 32'h3000; exp_wstrb = 4'b1100; exp_we = 1; exp_wdata = 32'hABCDABCD;
        issue_op(32'h3000, 32'h1234ABCD, 32'd2, 32'h1C, 6'd9, 1'b1, 4'b1001);
        mem_serve(0, 1'b0, 32'h0);
        done_chk("sh", 32'h0, 1'b0, 6'd9);

        // SB ea=0x6001
        exp_addr = 32'h6000; exp_wstrb = 4'b0010; exp_wdata = 32'hCDCDCDCD;
        issue_op(32'h6000, 32'h1234ABCD, 32'd1, 32'h20, 6'd1, 1'b0, 4'b1000);
        mem_serve(1, 1'b0, 32'h0);
        done_chk("sb", 32'h0, 1'b0, 6'd1);

        // LH signed ea=0x5002 with gnt withheld 5 cycles
        exp_addr = 32'h5000; exp_wstrb = 4'b1100; exp_we = 0;
        issue_op(32'h5000, 32'h0, 32'd2, 32'h24, 6'd10, 1'b1, 4'b0001);
        mem_serve(5, 1'b0, 32'h9ABC1234);
        done_chk("lh", 32'hFFFF9ABC, 1'b1, 6'd10);

        // LHU via negative offset: 0x5010 - 14 = 0x5002
        issue_op(32'h5010, 32'h0, 32'hFFFFFFF2, 32'h28, 6'd11, 1'b1, 4'b0101);
        mem_serve(0, 1'b0, 32'h9ABC1234);
        done_chk("lhu", 32'h00009ABC, 1'b1, 6'd11);

        // Misaligned LW ea=0x4001
        issue_op(32'h4000, 32'h0, 32'd1, 32'h80, 6'd3, 1'b1, 4'b0010);
        @(negedge clk_i);
        chk("mis_req", dmem.dmem_req_o, 0);
        chk("mis_flag", misalign_o, 1);
        chk("mis_pc", fault_pc_o, 32'h80);
        chk("mis_done", done_o, 1);
        chk("mis_rv", result_valid_o, 0);

        // Misaligned LH killed in DONE: strobes suppressed
        issue_op(32'h4000, 32'h0, 32'd3, 32'h84, 6'd3, 1'b1, 4'b0001);
        kill_i = 1'b1;
        @(negedge clk_i);
        chk("kdone_done", done_o, 0);
        chk("kdone_mis", misalign_o, 0);
        @(posedge clk_i); #1;
        kill_i = 1'b0;

        // Kill in WAIT: drain rvalid, no completion
        exp_addr = 32'h7000; exp_wstrb = 4'b1111;
        issue_op(32'h7000, 32'h0, 32'd0, 32'h30, 6'd2, 1'b1, 4'b0010);
        @(negedge clk_i);
        chk("kw_req", dmem.dmem_req_o, 1);
        dmem.dmem_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        dmem.dmem_gnt_i = 1'b0;
        kill_i = 1'b1;
        @(posedge clk_i); #1;
        kill_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            chk("kw_busy", busy_o, 1);
            chk("kw_done", done_o, 0);
            @(posedge clk_i); #1;
        end
        dmem.dmem_rvalid_i = 1'b1;
        dmem.dmem_rdata_i  = 32'h55555555;
        @(negedge clk_i);
        chk("kw_busy_rv", busy_o, 1);
        @(posedge clk_i); #1;
        dmem.dmem_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk("kw_idle", busy_o, 0);
        chk("kw_nodone", done_o, 0);
        chk("kw_norv", result_valid_o, 0);

        // Kill in REQ
        issue_op(32'h7000, 32'h0, 32'd0, 32'h34, 6'd2, 1'b1, 4'b0010);
        @(negedge clk_i);
        chk("kr_req", dmem.dmem_req_o, 1);
        kill_i = 1'b1;
        @(posedge clk_i); #1;
        kill_i = 1'b0;
        @(negedge clk_i);
        chk("kr_req_low", dmem.dmem_req_o, 0);
        chk("kr_busy", busy_o, 0);

        // Issue with kill in IDLE is ignored
        @(posedge clk_i); #1;
        issue_i = 1'b1; kill_i = 1'b1; ldst_type_i = 4'b0010;
        @(posedge clk_i); #1;
        issue_i = 1'b0; kill_i = 1'b0;
        @(negedge clk_i);
        chk("ki_busy", busy_o, 0);
        chk("ki_req", dmem.dmem_req_o, 0);

        // Async reset mid-REQ
        issue_op(32'h8000, 32'h0, 32'd0, 32'h38, 6'd4, 1'b1, 4'b0010);
        @(negedge clk_i);
        chk("ar_req", dmem.dmem_req_o, 1);
        #1 reset_i = 1'b0;
        #1;
        chk("ar_req0", dmem.dmem_req_o, 0);
        chk("ar_busy0", busy_o, 0);
        chk("ar_addr0", dmem.dmem_addr_o, 0);
        chk("ar_strb0", dmem.dmem_wstrb_o, 0);
        @(negedge clk_i);
        reset_i = 1'b1;
        repeat (2) @(posedge clk_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
